// File: rtl/wr_fram_pack_if.sv
// wr_fram_pack_if: stream, burst-handshake and status bundle of the write-side frame packer.
//   in_data/in_valid/in_eol/in_ready : narrow pixel stream into the packer
//   burst_req/burst_ack/burst_len    : burst offer to the DDR write master
//   out_data/out_valid/out_ready/out_last : wide-word stream to the write master
//   level                            : committed wide words held in the buffer
// modport slave is the packer; modport master is its environment.
interface wr_fram_pack_if #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 256,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned BURST_LEN = 16
) ();
  localparam int unsigned LEN_W = $clog2(BURST_LEN) + 1;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_eol;
  logic                 in_ready;
  logic                 burst_req;
  logic                 burst_ack;
  logic [LEN_W-1:0]     burst_len;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [LVL_W-1:0]     level;

  modport slave (
    input  in_data, in_valid, in_eol, burst_ack, out_ready,
    output in_ready, burst_req, burst_len, out_data, out_valid, out_last, level
  );

  modport master (
    output in_data, in_valid, in_eol, burst_ack, out_ready,
    input  in_ready, burst_req, burst_len, out_data, out_valid, out_last, level
  );
endinterface

// File: rtl/wr_fram_pack.sv
// wr_fram_pack: packs RATIO narrow input words into one wide word, buffers wide
// words in a DEPTH-entry RAM and hands them out as length-tagged bursts.
// An eol beat commits the partial word zero-padded and lets a short final burst drain.
// Ports:
//   clk   : single clock
//   rst_n : synchronous active-low reset
//   bus   : wr_fram_pack_if.slave (input stream, burst handshake, output stream, level)
module wr_fram_pack #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 256,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  wr_fram_pack_if.slave bus
);
  localparam int unsigned RATIO  = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned LANE_W = $clog2(RATIO);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned LEN_W  = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t               state_q, state_nxt;
  logic                 burst_req_q, burst_req_nxt;
  logic [LEN_W-1:0]     burst_len_q, burst_len_nxt;
  logic                 start_burst;

  logic [LANE_W-1:0]    lane_cnt_q;
  logic [OUT_WIDTH-1:0] pack_q;
  logic [OUT_WIDTH-1:0] commit_word;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [LVL_W-1:0]     level_q, level_nxt;
  logic                 in_ready_q;
  logic                 flush_q;

  logic [LEN_W-1:0]     rd_left_q;
  logic [LEN_W-1:0]     load_left_q;
  logic [OUT_WIDTH-1:0] ram_q;
  logic                 ram_valid_q;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic                 out_valid_q;
  logic                 out_last_q;

  logic [OUT_WIDTH-1:0] mem [DEPTH];

  logic in_fire, last_lane, commit, out_fire, load, issue;

  assign in_fire   = bus.in_valid && in_ready_q;
  assign last_lane = (lane_cnt_q == LANE_W'(RATIO - 1));
  assign commit    = in_fire && (last_lane || bus.in_eol);
  assign out_fire  = out_valid_q && bus.out_ready;
  // Output register refills from the prefetch register whenever it is empty or being taken.
  assign load      = ram_valid_q && (!out_valid_q || bus.out_ready);
  // Issue a RAM read when the prefetch register will be free next cycle.
  assign issue     = (rd_left_q != '0) && (!ram_valid_q || load);

  // Current beat merged into the partial word; lanes above it are still zero.
  always_comb begin
    commit_word = pack_q;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (lane_cnt_q == LANE_W'(k)) begin
        commit_word[k*IN_WIDTH +: IN_WIDTH] = bus.in_data;
      end
    end
  end

  // Committed-word count: commit and output handshake in the same cycle cancel.
  always_comb begin
    level_nxt = level_q;
    if (commit && !out_fire) begin
      level_nxt = level_q + LVL_W'(1);
    end else if (!commit && out_fire) begin
      level_nxt = level_q - LVL_W'(1);
    end
  end

  // Burst FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_req_q <= 1'b0;
      burst_len_q <= '0;
    end else begin
      state_q     <= state_nxt;
      burst_req_q <= burst_req_nxt;
      burst_len_q <= burst_len_nxt;
    end
  end

  // Burst FSM next state and registered outputs.
  always_comb begin
    state_nxt     = state_q;
    burst_len_nxt = burst_len_q;
    start_burst   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((level_q >= LVL_W'(BURST_LEN)) || (flush_q && (level_q != '0))) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.burst_ack) begin
          state_nxt     = XFER;
          start_burst   = 1'b1;
          burst_len_nxt = (level_q >= LVL_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(level_q);
        end
      end
      XFER: begin
        if (out_fire && out_last_q) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    burst_req_nxt = (state_nxt == REQ);
  end

  // Input packing, write pointer, level, in_ready and flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_cnt_q <= '0;
      pack_q     <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      if (in_fire) begin
        if (commit) begin
          lane_cnt_q <= '0;
          pack_q     <= '0;
          wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
        end else begin
          lane_cnt_q <= lane_cnt_q + LANE_W'(1);
          pack_q     <= commit_word;
        end
      end
      level_q    <= level_nxt;
      // Registered from the updated count, so the cycle level reaches DEPTH already has it low.
      in_ready_q <= (level_nxt < LVL_W'(DEPTH));
      // An eol commit re-arms the flush even when a short burst is granted in the same cycle.
      if (commit && bus.in_eol) begin
        flush_q <= 1'b1;
      end else if (start_burst && (level_q <= LVL_W'(BURST_LEN))) begin
        flush_q <= 1'b0;
      end
    end
  end

  // Buffer RAM: synchronous write, registered read into the prefetch slot.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[wr_ptr_q] <= commit_word;
    end
    if (issue) begin
      ram_q <= mem[rd_ptr_q];
    end
  end

  // Read side: read issue, prefetch slot and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      rd_left_q   <= '0;
      load_left_q <= '0;
      ram_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (start_burst) begin
        rd_left_q <= burst_len_nxt;
      end else if (issue) begin
        rd_left_q <= rd_left_q - LEN_W'(1);
      end
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end

      if (issue) begin
        ram_valid_q <= 1'b1;
      end else if (load) begin
        ram_valid_q <= 1'b0;
      end

      if (start_burst) begin
        load_left_q <= burst_len_nxt;
      end else if (load) begin
        load_left_q <= load_left_q - LEN_W'(1);
      end

      if (load) begin
        out_data_q  <= ram_q;
        out_valid_q <= 1'b1;
        out_last_q  <= (load_left_q == LEN_W'(1));
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.burst_req = burst_req_q;
  assign bus.burst_len = burst_len_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.level     = level_q;
endmodule

// File: tb/tb_wr_fram_pack.sv
// tb_wr_fram_pack: self-checking bench for wr_fram_pack with default parameters.
// A queue of expected wide words is built from the accepted beats; bursts are
// drained against it with optional random back-pressure.
module tb_wr_fram_pack;
  localparam int unsigned IW    = 32;
  localparam int unsigned OW    = 256;
  localparam int unsigned DP    = 512;
  localparam int unsigned BL    = 16;
  localparam int unsigned RATIO = OW / IW;

  logic clk;
  logic rst_n;

  wr_fram_pack_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DP), .BURST_LEN(BL)) bus ();

  wr_fram_pack #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DP), .BURST_LEN(BL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: expected wide words in commit order, partial word, line-end flag.
  logic [OW-1:0] mq [$];
  logic [OW-1:0] m_word;
  int            m_cnt;
  bit            m_flush;
  bit            feed_done;

  typedef struct {
    int beats;
    bit eol;
    int exp_level;
    bit exp_req;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    mq.delete();
    m_word  = '0;
    m_cnt   = 0;
    m_flush = 1'b0;
  endfunction

  function automatic void model_push(input logic [IW-1:0] d, input bit eol);
    m_word = m_word | (OW'(d) << (m_cnt * IW));
    m_cnt++;
    if (m_cnt == RATIO || eol) begin
      mq.push_back(m_word);
      m_word = '0;
      m_cnt  = 0;
      if (eol) m_flush = 1'b1;
    end
  endfunction

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_eol    = 1'b0;
    bus.burst_ack = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    model_clear();
  endtask

  // Sends n beats base..base+n-1, eol optionally on the last; gap_pct inserts idle cycles.
  task automatic feed(input int n, input int base, input bit eol, input int gap_pct);
    int  guard;
    bit  e;
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.in_valid = 1'b0;
        step();
      end
      e            = eol && (i == n - 1);
      bus.in_valid = 1'b1;
      bus.in_data  = IW'(base + i);
      bus.in_eol   = e;
      guard = 0;
      while (!bus.in_ready && guard < 100) begin
        step();
        guard++;
      end
      if (!bus.in_ready) begin
        chk("in_ready_timeout", OW'(bus.in_ready), OW'(1));
        bus.in_valid = 1'b0;
        bus.in_eol   = 1'b0;
        return;
      end
      step();
      model_push(IW'(base + i), e);
    end
    bus.in_valid = 1'b0;
    bus.in_eol   = 1'b0;
  endtask

  // Grants one burst and consumes it; exp_len <= 0 means only range-check the length.
  task automatic drain_one(input int exp_len, input bit rnd);
    int            len, got, cyc, first, dut_len;
    bit            stalled;
    logic [OW-1:0] prev_d, exp_w;
    cyc = 0;
    while (!bus.burst_req && cyc < 50) begin
      step();
      cyc++;
    end
    chk("burst_req", OW'(bus.burst_req), OW'(1));
    if (!bus.burst_req) return;
    bus.burst_ack = 1'b1;
    step();
    bus.burst_ack = 1'b0;
    dut_len = int'(bus.burst_len);
    if (exp_len > 0) begin
      chk("burst_len", OW'(bus.burst_len), OW'(exp_len));
      len = exp_len;
    end else begin
      chk("burst_len_range", OW'(dut_len >= 1 && dut_len <= int'(BL)), OW'(1));
      len = (dut_len >= 1 && dut_len <= int'(BL)) ? dut_len : 1;
    end
    got     = 0;
    cyc     = 0;
    first   = -1;
    stalled = 1'b0;
    prev_d  = '0;
    while (got < len && cyc < 2000) begin
      bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stalled) begin
        chk("hold_valid", OW'(bus.out_valid), OW'(1));
        chk("hold_data", bus.out_data, prev_d);
      end
      if (bus.out_valid) begin
        if (first < 0) first = cyc;
        chk("out_last", OW'(bus.out_last), OW'(got == len - 1));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (mq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_word: got %0h expected none", bus.out_data);
        end else begin
          exp_w = mq.pop_front();
          chk("out_data", bus.out_data, exp_w);
        end
        got++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      prev_d  = bus.out_data;
      step();
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk("burst_words", OW'(got), OW'(len));
    chk("first_latency", OW'(first >= 0 && first <= 2), OW'(1));
    chk("valid_after_last", OW'(bus.out_valid), OW'(0));
  endtask

  // Drains every burst the model says is available, then checks the buffer is quiet.
  task automatic drain_all(input bit rnd);
    int sz;
    int guard;
    guard = 0;
    while ((mq.size() >= int'(BL) || (m_flush && mq.size() > 0)) && guard < 100) begin
      sz = mq.size();
      drain_one((sz < int'(BL)) ? sz : int'(BL), rnd);
      if (sz <= int'(BL)) m_flush = 1'b0;
      guard++;
    end
    repeat (4) step();
    chk("idle_req", OW'(bus.burst_req), OW'(0));
    chk("level_after", OW'(bus.level), OW'(mq.size()));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [8];
    int   w;
    int   got;

    vt[0] = '{128, 1'b0, 16, 1'b1};
    vt[1] = '{13,  1'b1, 2,  1'b1};
    vt[2] = '{8,   1'b1, 1,  1'b1};
    vt[3] = '{7,   1'b0, 0,  1'b0};
    vt[4] = '{9,   1'b1, 2,  1'b1};
    vt[5] = '{136, 1'b1, 17, 1'b1};
    vt[6] = '{1,   1'b1, 1,  1'b1};
    vt[7] = '{16,  1'b0, 2,  1'b0};

    // Reset values with in_valid held high.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hdead_beef;
    bus.in_eol    = 1'b0;
    bus.burst_ack = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    feed_done = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", OW'(bus.in_ready), OW'(0));
    chk("rst_burst_req", OW'(bus.burst_req), OW'(0));
    chk("rst_burst_len", OW'(bus.burst_len), OW'(0));
    chk("rst_out_valid", OW'(bus.out_valid), OW'(0));
    chk("rst_out_last", OW'(bus.out_last), OW'(0));
    chk("rst_out_data", bus.out_data, OW'(0));
    chk("rst_level", OW'(bus.level), OW'(0));
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", OW'(bus.in_ready), OW'(1));
    bus.in_valid = 1'b0;
    step();
    chk("rel_level", OW'(bus.level), OW'(0));

    // Ack while idle is ignored.
    bus.burst_ack = 1'b1;
    step();
    bus.burst_ack = 1'b0;
    step();
    step();
    chk("ack_idle_req", OW'(bus.burst_req), OW'(0));
    chk("ack_idle_valid", OW'(bus.out_valid), OW'(0));
    chk("ack_idle_len", OW'(bus.burst_len), OW'(0));

    // Table of line shapes: level and request after the line, then full drain.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      feed(vt[i].beats, i * 1000, vt[i].eol, 0);
      chk("tbl_level", OW'(bus.level), OW'(vt[i].exp_level));
      if (vt[i].exp_req) begin
        w = 0;
        while (!bus.burst_req && w < 2) begin
          step();
          w++;
        end
        chk("tbl_req", OW'(bus.burst_req), OW'(1));
      end else begin
        repeat (3) step();
        chk("tbl_noreq", OW'(bus.burst_req), OW'(0));
      end
      drain_all(i[0]);
    end

    // Full buffer: 4096 beats without draining, then 32 bursts across the pointer wrap.
    do_reset();
    feed(4096, 32'h0001_0000, 1'b0, 0);
    chk("full_level", OW'(bus.level), OW'(DP));
    chk("full_in_ready", OW'(bus.in_ready), OW'(0));
    chk("full_req", OW'(bus.burst_req), OW'(1));
    drain_all(1'b0);

    // Reset in the middle of a burst, then a fresh stream from the start.
    do_reset();
    feed(128, 20000, 1'b0, 0);
    w = 0;
    while (!bus.burst_req && w < 10) begin
      step();
      w++;
    end
    bus.burst_ack = 1'b1;
    step();
    bus.burst_ack = 1'b0;
    bus.out_ready = 1'b1;
    got = 0;
    w   = 0;
    while (got < 5 && w < 50) begin
      if (bus.out_valid) begin
        chk("mid_data", bus.out_data, mq.pop_front());
        got++;
      end
      step();
      w++;
    end
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", OW'(bus.out_valid), OW'(0));
    chk("mid_rst_level", OW'(bus.level), OW'(0));
    chk("mid_rst_req", OW'(bus.burst_req), OW'(0));
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    step();
    model_clear();
    feed(128, 30000, 1'b0, 0);
    drain_all(1'b1);

    // Random lines with idle gaps, drained concurrently under random back-pressure.
    do_reset();
    feed_done = 1'b0;
    fork
      begin
        for (int l = 0; l < 14; l++) begin
          feed($urandom_range(1, 40), 40000 + l * 100, 1'b1, 20);
        end
        feed_done = 1'b1;
      end
      begin
        int guard;
        guard = 0;
        while (!(feed_done && mq.size() == 0) && guard < 20000) begin
          if (bus.burst_req) drain_one(-1, 1'b1);
          else step();
          guard++;
        end
        chk("rand_drained", OW'(mq.size()), OW'(0));
      end
    join
    repeat (4) step();
    chk("rand_level", OW'(bus.level), OW'(0));
    chk("rand_req", OW'(bus.burst_req), OW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
